fm_sb_rd_arbiter: RTL and testbench
===================================

Name: fm_sb_rd_arbiter

Overview:
- Shares one 32-bit AXI-side monitoring readout lane among SB_N spy-buffer sources (27 mapped: 3 stations x 3 threads x slc/hit/ptcalc).
- Each source offers one frame of up to MON_DW bits with a valid flag, in the fm_rt format (fm_data, fm_vld).
- The block grants sources round-robin, latches the granted frame, and serialises it LSB-first into AXI_DW words with per-packet source ID and last flag.

Parameters:
- SB_N, 27, number of spy-buffer sources.
- MON_DW, 256, frame width (mon_dw_max).
- AXI_DW, 32, output word width.
- ID_W, 5, source-ID width; must satisfy 2**ID_W >= SB_N.
- NW_W, 4, word-count field width; must hold MON_DW/AXI_DW.

Ports:
- clk  in  1  single block clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  global arbitration enable.
- sb_mask  in  SB_N  per-source enable; 1 = eligible.
- sb_nwords  in  SB_N*NW_W  per-source packet length in AXI words (sb_dw/axi_dw); static config.
- fm_data  in  SB_N*MON_DW  per-source frame.
- fm_vld  in  SB_N  per-source frame valid; held until accepted.
- fm_rdy  out  SB_N  one-cycle accept pulse to the granted source.
- out_data  out  AXI_DW  serialised word.
- out_vld  out  1  word valid.
- out_rdy  in  1  downstream ready.
- out_last  out  1  final word of packet.
- out_id  out  ID_W  source index of current packet.
- busy  out  1  packet in flight.
- pkt_cnt  out  32  completed-packet counter.

Behaviour:
- Reset (async, rst_n=0): fm_rdy=0, out_vld=0, out_last=0, out_data=0, out_id=0, busy=0, pkt_cnt=0, rr pointer=0, FSM=IDLE. Reset mid-packet abandons the packet; no partial completion is counted.
- FSM states: IDLE, SEND.
- IDLE:
  - eligible = fm_vld & sb_mask, gated by enable.
  - If eligible is non-zero, select the first set bit searching upward from the rr pointer, wrapping modulo SB_N.
  - On the next edge: latch fm_data[g] into the shift register, latch n = sb_nwords[g], pulse fm_rdy[g] for exactly one cycle, set out_id=g, out_vld=1, busy=1, and go to SEND.
  - Latency from fm_vld seen to first out_vld is 1 cycle.
- Length rules:
  - n=0 is treated as 1.
  - n > MON_DW/AXI_DW is clamped to MON_DW/AXI_DW.
- SEND:
  - out_data = bits [AXI_DW-1:0] of the shift register.
  - On out_vld & out_rdy, shift right by AXI_DW and increment the word index.
  - out_last=1 when word index = n-1.
  - Accepting the last word: out_vld=0, out_last=0, busy=0, pkt_cnt+=1 (wraps at 2^32), rr pointer = (g+1) mod SB_N, go to IDLE.
  - out_vld low with out_rdy high has no effect.
  - out_data, out_last and out_id stay stable while out_vld & !out_rdy (AXI-stream hold rule).
- Back-to-back: at least one IDLE cycle between packets; the next grant is evaluated in that IDLE cycle.
- Mid-packet changes:
  - enable deassert mid-packet: the current packet completes; no new grant follows.
  - sb_mask change mid-packet: affects only subsequent arbitration.
  - fm_vld drop of an ungranted source: that source is simply not eligible.
- Only one fm_rdy bit is high in any cycle. A source is never granted twice in a row while another eligible source is waiting.
- sb_nwords and fm_data of non-granted sources are don't-care.

Test Plan:
- Reset/idle: rst_n low 3 cycles with fm_vld=all-ones -> all outputs 0. After release with enable=0, fm_rdy stays 0 for 20 cycles.
- Single packet: source 5, nwords=3, fm_data[95:0]=0x33333333_22222222_11111111, out_rdy=1 -> fm_rdy[5] pulses 1 cycle after fm_vld. out_data=0x11111111,0x22222222,0x33333333 on consecutive cycles; out_last only on the third word; out_id=5; pkt_cnt=1.
- Round-robin: sources 0, 3 and 26 valid continuously, nwords=1 -> grant order 0,3,26,0,3 (wrap from 26 to 0); each grant separated by one IDLE cycle.
- Backpressure: nwords=8, out_rdy toggling 1,0,0,1,... -> exactly 8 words transferred; data held stable during stalls; out_last asserted only on word 8.
- Boundaries:
  - nwords=0 -> one-word packet with out_last.
  - nwords=15 -> 8 words.
  - sb_mask[3]=0 with fm_vld[3]=1 -> source 3 never granted.
- Disruption:
  - enable dropped after word 2 of 4 -> words 3 and 4 still sent, then no further grants.
  - rst_n asserted mid-packet -> outputs 0 immediately; pkt_cnt unchanged from its pre-packet value, then 0.

Source files
------------

// File: rtl/fm_sb_rd_arbiter.sv
// Round-robin readout arbiter: picks one spy-buffer source at a time,
// captures its frame and streams it out LSB-first as AXI_DW-bit words.
//
// Handshake rules: a word moves on out_data when out_vld & out_rdy are
// both high at a rising clk edge; while out_vld is high and out_rdy is low,
// out_data/out_last/out_id hold.
// A source frame is accepted by a one-cycle fm_rdy pulse on the edge that
// grants it; the source is expected to hold fm_vld until that pulse.
module fm_sb_rd_arbiter #(
    parameter int SB_N   = 27,
    parameter int MON_DW = 256,
    parameter int AXI_DW = 32,
    parameter int ID_W   = 5,
    parameter int NW_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [SB_N-1:0]        sb_mask,
    input  logic [SB_N*NW_W-1:0]   sb_nwords,
    input  logic [SB_N*MON_DW-1:0] fm_data,
    input  logic [SB_N-1:0]        fm_vld,
    output logic [SB_N-1:0]        fm_rdy,
    output logic [AXI_DW-1:0]      out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_last,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy,
    output logic [31:0]            pkt_cnt
);

    localparam int MAX_WORDS = MON_DW / AXI_DW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [MON_DW-1:0]   shreg_q, shreg_d;
    logic [NW_W-1:0]     nw_q, nw_d;
    logic [NW_W-1:0]     widx_q, widx_d;
    logic [SB_N-1:0]     fm_rdy_q, fm_rdy_d;
    logic                out_vld_q, out_vld_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                busy_q, busy_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d;

    logic [SB_N-1:0]     elig;
    logic                found;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W:0]       cand_sum;
    logic [ID_W-1:0]     cand_idx;
    logic [MON_DW-1:0]   sel_data;
    logic [NW_W-1:0]     sel_nw;
    logic [NW_W-1:0]     sel_nw_clamped;
    logic                last_word;

    // Rotating-priority search: first eligible source at or above rr_q, wrapping.
    always_comb begin
        elig     = enable ? (fm_vld & sb_mask) : '0;
        found    = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand_idx = '0;
        for (int k = 0; k < SB_N; k++) begin
            cand_sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(SB_N)) begin
                cand_sum = cand_sum - (ID_W+1)'(SB_N);
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (!found && elig[cand_idx]) begin
                found   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // Pick the granted source's frame and length; length 0 means 1, oversize is capped.
    always_comb begin
        sel_data = '0;
        sel_nw   = '0;
        for (int i = 0; i < SB_N; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_data = fm_data[i*MON_DW +: MON_DW];
                sel_nw   = sb_nwords[i*NW_W +: NW_W];
            end
        end
        if (sel_nw == '0) begin
            sel_nw_clamped = NW_W'(1);
        end else if (sel_nw > NW_W'(MAX_WORDS)) begin
            sel_nw_clamped = NW_W'(MAX_WORDS);
        end else begin
            sel_nw_clamped = sel_nw;
        end
    end

    assign last_word = (state_q == ST_SEND) && (widx_q == (nw_q - NW_W'(1)));

    // Next-state logic for the grant/serialise FSM.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        shreg_d   = shreg_q;
        nw_d      = nw_q;
        widx_d    = widx_q;
        fm_rdy_d  = '0;
        out_vld_d = out_vld_q;
        out_id_d  = out_id_q;
        busy_d    = busy_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    shreg_d           = sel_data;
                    nw_d              = sel_nw_clamped;
                    widx_d            = '0;
                    fm_rdy_d[gnt_idx] = 1'b1;
                    out_id_d          = gnt_idx;
                    out_vld_d         = 1'b1;
                    busy_d            = 1'b1;
                    state_d           = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_vld_q && out_rdy) begin
                    if (last_word) begin
                        out_vld_d = 1'b0;
                        busy_d    = 1'b0;
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        rr_d      = (out_id_q == ID_W'(SB_N-1)) ? '0 : out_id_q + ID_W'(1);
                        state_d   = ST_IDLE;
                    end else begin
                        shreg_d = shreg_q >> AXI_DW;
                        widx_d  = widx_q + NW_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            shreg_q   <= '0;
            nw_q      <= '0;
            widx_q    <= '0;
            fm_rdy_q  <= '0;
            out_vld_q <= 1'b0;
            out_id_q  <= '0;
            busy_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            shreg_q   <= shreg_d;
            nw_q      <= nw_d;
            widx_q    <= widx_d;
            fm_rdy_q  <= fm_rdy_d;
            out_vld_q <= out_vld_d;
            out_id_q  <= out_id_d;
            busy_q    <= busy_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign fm_rdy   = fm_rdy_q;
    assign out_data = shreg_q[AXI_DW-1:0];
    assign out_vld  = out_vld_q;
    assign out_last = last_word;
    assign out_id   = out_id_q;
    assign busy     = busy_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_fm_sb_rd_arbiter.sv
// Directed bench for fm_sb_rd_arbiter with an expected-word scoreboard.
module tb_fm_sb_rd_arbiter;

    localparam int SB_N   = 27;
    localparam int MON_DW = 256;
    localparam int AXI_DW = 32;
    localparam int ID_W   = 5;
    localparam int NW_W   = 4;
    localparam int EW     = ID_W + 1 + AXI_DW;

    // clock / reset
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                   enable;
    logic [SB_N-1:0]        sb_mask;
    logic [SB_N*NW_W-1:0]   sb_nwords;
    logic [SB_N*MON_DW-1:0] fm_data;
    logic [SB_N-1:0]        fm_vld;
    logic [SB_N-1:0]        fm_rdy;
    logic [AXI_DW-1:0]      out_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   out_last;
    logic [ID_W-1:0]        out_id;
    logic                   busy;
    logic [31:0]            pkt_cnt;

    fm_sb_rd_arbiter #(
        .SB_N(SB_N), .MON_DW(MON_DW), .AXI_DW(AXI_DW), .ID_W(ID_W), .NW_W(NW_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sb_mask(sb_mask),
        .sb_nwords(sb_nwords), .fm_data(fm_data), .fm_vld(fm_vld), .fm_rdy(fm_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
        .out_id(out_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int            gnt_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            exp_pkt = 0;
    logic [EW-1:0] obs_w;
    logic [EW-1:0] exp_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // Offer one frame from an otherwise idle system; mode 0 = out_rdy high, 1 = 1,0,0 pattern.
    task automatic send_pkt(input int src, input int nw, input logic [MON_DW-1:0] d, input int mode);
        int n;
        int cyc;
        n = (nw == 0) ? 1 : ((nw > MON_DW/AXI_DW) ? MON_DW/AXI_DW : nw);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({ID_W'(src), (k == n-1), d[k*AXI_DW +: AXI_DW]});
        end
        gnt_q.push_back(src);
        fm_data[src*MON_DW +: MON_DW] = d;
        sb_nwords[src*NW_W +: NW_W]   = NW_W'(nw);
        fm_vld[src] = 1'b1;
        out_rdy = 1'b1;
        tick();
        check("grant_latency", 64'(fm_rdy), 64'(1) << src);
        check("first_vld", 64'(out_vld), 64'd1);
        check("out_id", 64'(out_id), 64'(src));
        fm_vld[src] = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            out_rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            tick();
            cyc++;
        end
        out_rdy = 1'b1;
        check("pkt_done", 64'(busy), 64'd0);
        if (mode == 0) check("pkt_cycles", 64'(cyc), 64'(n));
        exp_pkt++;
        check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        check("words_left", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Output monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                obs_w = {out_id, out_last, out_data};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $error("FAIL unexpected_word observed=%0h expected=none", obs_w);
                end else if (out_rdy) begin
                    exp_w = exp_q.pop_front();
                    check("word", 64'(obs_w), 64'(exp_w));
                end else begin
                    check("stall_hold", 64'(obs_w), 64'(exp_q[0]));
                end
            end
            if (fm_rdy != '0) begin
                check("rdy_onehot", 64'($countones(fm_rdy)), 64'd1);
                if (gnt_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $error("FAIL unexpected_grant observed=%0h expected=none", fm_rdy);
                end else begin
                    check("grant_id", 64'(fm_rdy), 64'(1) << gnt_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MON_DW-1:0] d;
        int cnt;
        int last_c;
        int pre_cnt;

        // Reset with every source requesting.
        rst_n     = 1'b0;
        enable    = 1'b1;
        sb_mask   = '1;
        sb_nwords = '0;
        fm_data   = '0;
        fm_vld    = '1;
        out_rdy   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_fm_rdy", 64'(fm_rdy), 64'd0);
            check("rst_out_vld", 64'(out_vld), 64'd0);
            check("rst_out_last", 64'(out_last), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_out_id", 64'(out_id), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("disabled_fm_rdy", 64'(fm_rdy), 64'd0);
            check("disabled_out_vld", 64'(out_vld), 64'd0);
        end
        fm_vld = '0;
        enable = 1'b1;
        tick();

        // Single three-word packet from source 5.
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             32'h33333333, 32'h22222222, 32'h11111111};
        send_pkt(5, 3, d, 0);

        // Reset pulse so round-robin starts from pointer 0.
        rst_n = 1'b0;
        tick();
        check("rst2_pkt_cnt", 64'(pkt_cnt), 64'd0);
        rst_n   = 1'b1;
        exp_pkt = 0;
        tick();

        // Round-robin across sources 0, 3 and 26, all held valid.
        sb_nwords[0*NW_W +: NW_W]  = NW_W'(1);
        sb_nwords[3*NW_W +: NW_W]  = NW_W'(1);
        sb_nwords[26*NW_W +: NW_W] = NW_W'(1);
        fm_data[0*MON_DW +: AXI_DW]  = 32'hA000_0000;
        fm_data[3*MON_DW +: AXI_DW]  = 32'hA000_0003;
        fm_data[26*MON_DW +: AXI_DW] = 32'hA000_001A;
        gnt_q.push_back(0);  exp_q.push_back({ID_W'(0),  1'b1, 32'hA000_0000});
        gnt_q.push_back(3);  exp_q.push_back({ID_W'(3),  1'b1, 32'hA000_0003});
        gnt_q.push_back(26); exp_q.push_back({ID_W'(26), 1'b1, 32'hA000_001A});
        gnt_q.push_back(0);  exp_q.push_back({ID_W'(0),  1'b1, 32'hA000_0000});
        gnt_q.push_back(3);  exp_q.push_back({ID_W'(3),  1'b1, 32'hA000_0003});
        fm_vld[0]  = 1'b1;
        fm_vld[3]  = 1'b1;
        fm_vld[26] = 1'b1;
        cnt    = 0;
        last_c = 0;
        for (int c = 0; c < 60 && cnt < 5; c++) begin
            tick();
            if (fm_rdy != '0) begin
                if (cnt > 0) check("rr_gap", 64'(c - last_c), 64'd2);
                last_c = c;
                cnt++;
                if (cnt == 5) fm_vld = '0;
            end
        end
        check("rr_grants", 64'(cnt), 64'd5);
        wait_idle("rr_idle");
        exp_pkt += 5;
        check("rr_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        check("rr_words_left", 64'(exp_q.size()), 64'd0);
        tick();

        // Backpressure: eight words with out_rdy 1,0,0 repeating.
        for (int k = 0; k < 8; k++) d[k*AXI_DW +: AXI_DW] = $urandom();
        send_pkt(11, 8, d, 1);

        // Length boundaries.
        for (int k = 0; k < 8; k++) d[k*AXI_DW +: AXI_DW] = $urandom();
        send_pkt(20, 0, d, 0);
        for (int k = 0; k < 8; k++) d[k*AXI_DW +: AXI_DW] = $urandom();
        send_pkt(14, 15, d, 0);

        // Masked source 3 competes with source 4; only 4 may win.
        sb_mask[3] = 1'b0;
        sb_nwords[4*NW_W +: NW_W] = NW_W'(1);
        fm_data[4*MON_DW +: AXI_DW] = 32'hB000_0004;
        gnt_q.push_back(4);
        exp_q.push_back({ID_W'(4), 1'b1, 32'hB000_0004});
        fm_vld[3] = 1'b1;
        fm_vld[4] = 1'b1;
        tick();
        check("mask_grant", 64'(fm_rdy), 64'(1) << 4);
        fm_vld[4] = 1'b0;
        wait_idle("mask_idle");
        exp_pkt++;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mask_no_grant", 64'(fm_rdy), 64'd0);
        end
        check("mask_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        fm_vld[3] = 1'b0;
        sb_mask   = '1;
        tick();

        // Enable dropped after word 2 of 4; packet finishes, nothing further granted.
        for (int k = 0; k < 8; k++) d[k*AXI_DW +: AXI_DW] = $urandom();
        for (int k = 0; k < 4; k++) exp_q.push_back({ID_W'(7), (k == 3), d[k*AXI_DW +: AXI_DW]});
        gnt_q.push_back(7);
        fm_data[7*MON_DW +: MON_DW] = d;
        sb_nwords[7*NW_W +: NW_W]   = NW_W'(4);
        sb_nwords[9*NW_W +: NW_W]   = NW_W'(1);
        fm_vld[7] = 1'b1;
        tick();
        check("en_grant", 64'(fm_rdy), 64'(1) << 7);
        fm_vld[7] = 1'b0;
        fm_vld[9] = 1'b1;
        tick();
        tick();
        check("en_mid_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        wait_idle("en_idle");
        exp_pkt++;
        check("en_words_left", 64'(exp_q.size()), 64'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("en_no_grant", 64'(fm_rdy), 64'd0);
            check("en_no_vld", 64'(out_vld), 64'd0);
        end
        check("en_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        fm_vld[9] = 1'b0;
        enable    = 1'b1;
        tick();

        // Reset in the middle of an eight-word packet.
        pre_cnt = exp_pkt;
        for (int k = 0; k < 8; k++) d[k*AXI_DW +: AXI_DW] = $urandom();
        for (int k = 0; k < 8; k++) exp_q.push_back({ID_W'(2), (k == 7), d[k*AXI_DW +: AXI_DW]});
        gnt_q.push_back(2);
        fm_data[2*MON_DW +: MON_DW] = d;
        sb_nwords[2*NW_W +: NW_W]   = NW_W'(8);
        fm_vld[2] = 1'b1;
        tick();
        fm_vld[2] = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_pkt_cnt", 64'(pkt_cnt), 64'(pre_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_vld", 64'(out_vld), 64'd0);
        check("arst_out_last", 64'(out_last), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_id", 64'(out_id), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_fm_rdy", 64'(fm_rdy), 64'd0);
        check("arst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_vld", 64'(out_vld), 64'd0);
        end
        check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("post_rst_grants_left", 64'(gnt_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
